fft_control_param: RTL and testbench
====================================

Name: fft_control_param

Overview:
Parametrised successor of the radix-4 FFT control FSM. It supports a run-time selectable transform size from 16 to 2^MAX_LOG2N points, and uses a mixed radix-4/radix-2 schedule, with a final radix-2 stage when log2N is odd. It generates four-bank read/write addressing, bank rotation, twiddle addresses and A/B ping-pong write enables for the butterfly datapath and its memories. New behaviour: configurable butterfly pipeline latency, an abort input, and a busy flag.

Parameters:
MAX_LOG2N, 10, maximum log2 of transform size (even or odd, >=4)
PIPE_LAT, 4, butterfly datapath latency in clocks from read address to write data
ADDR_W, MAX_LOG2N-2, per-bank address width (derived, not overridden)

Ports:
iCLK  in  1  clock
iRESET  in  1  asynchronous reset, active low
iSTART  in  1  start pulse, sampled only in IDLE
iABORT  in  1  abandon transform, return to IDLE
iLOG2N  in  4  transform size log2, sampled with iSTART, legal 4..MAX_LOG2N
oADDR_RD_0..oADDR_RD_3  out  ADDR_W each  read address presented to bank 0..3
oBANK_RD_ROT  out  2  bank holding leg 0 of current read butterfly
oADDR_WR  out  4*ADDR_W  write addresses for banks 3..0, packed, bank 0 in LSBs
oBANK_WR_ROT  out  2  oBANK_RD_ROT delayed PIPE_LAT
oADDR_COEF  out  ADDR_W  twiddle ROM address
oWE_A, oWE_B  out  1 each  write enable for ping-pong memory A / B
oSOURCE_DATA  out  1  0 = read from A, 1 = read from B
oSOURCE_CONT  out  1  1 = FFT owns memories (equals oBUSY)
oBUT_TYPE  out  1  0 = radix-4, 1 = dual radix-2 (delayed like write side)
oBUSY  out  1  transform in progress
oRDY  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0.
- Sizing: N = 2^L with L latched from iLOG2N. Stage count S = ceil(L/2). Stages 0..S-1 are radix-4. If L is odd, the last stage is dual radix-2. Illegal L (<4 or >MAX_LOG2N) makes iSTART ignored.
- FSM: IDLE -> RUN on iSTART. RUN lasts N/4 cycles, cnt = 0..N/4-1. RUN -> DRAIN, which lasts PIPE_LAT cycles. DRAIN -> NEXT (1 cycle, stage++, cnt=0) -> RUN if stages remain, else DRAIN -> DONE (1 cycle, oRDY=1) -> IDLE.
- oBUSY is 1 in RUN/DRAIN/NEXT/DONE.
- Radix-4 stage s: span = N/4^(s+1), g = cnt/span, o = cnt%span. Leg j element e_j = g*4*span + j*span + o.
- Dual radix-2 stage: legs e_j = 4*cnt + j. Pairs are (0,1) and (2,3).
- Bank of element e = (sum of base-4 digits of e) mod 4; address = e>>2. Legs always occupy distinct banks.
- oADDR_RD_b = address of the leg in bank b. oBANK_RD_ROT = bank(e_0).
- oADDR_COEF = o*4^s for radix-4; 0 for radix-2.
- Read outputs are valid only in RUN; they hold 0 elsewhere.
- Write side: oADDR_WR, oBANK_WR_ROT and oBUT_TYPE are exact PIPE_LAT-cycle delays of the read-side values. The write enable is asserted for exactly N/4 cycles per stage, starting PIPE_LAT cycles after the first RUN cycle.
- Ping-pong: stage s reads A if s even (oSOURCE_DATA=0) and writes B (oWE_B); odd stages reverse. Result lies in B if S is odd, in A if S is even.
- Simultaneous events: iSTART while busy is ignored. iABORT has priority over all: the next state is IDLE and all outputs are cleared next cycle, no oRDY, and the delay line is flushed so no trailing write enables occur. iABORT and iSTART together in IDLE -> stay IDLE.
- Async reset mid-transform: identical to abort, immediate.
- Latency: first read address in cycle 1 after the iSTART edge. oRDY is in cycle S*(N/4+PIPE_LAT)+(S-1)+1.

Test Plan:
- Reset asserted mid-RUN -> all outputs 0 immediately; no oWE pulse after release.
- L=4, PIPE_LAT=4, start pulse:
  - 2 radix-4 stages of 4 read cycles each.
  - Stage 0: cnt=1 gives e={1,5,9,13} -> banks {1,2,3,0}, oBANK_RD_ROT=1, oADDR_COEF=1.
  - oRDY in cycle 18; oWE_B then oWE_A, 4 cycles each.
- L=5 -> S=3, last stage oBUT_TYPE=1, oADDR_COEF=0; oRDY in cycle 39; result in B (oWE_B in last stage).
- L=10 (max) -> 5 stages of 256 read cycles; oRDY in cycle 1305; every cycle the four read banks are distinct (bench assertion).
- iABORT at cycle 100 of the L=10 run -> oBUSY=0 next cycle, no oRDY, no further oWE. An immediate restart with L=4 then completes in 18 cycles.
- iSTART with iLOG2N=3 or 11 -> remains IDLE, oBUSY=0. A second iSTART while busy -> no effect, single oRDY.

Source files
------------

// File: rtl/fft_control_param_if.sv
// Control/address bundle between a host, the mixed-radix FFT sequencer and the
// butterfly datapath with its four-bank A/B ping-pong memories.
interface fft_control_param_if #(
  parameter int MAX_LOG2N = 10
);
  localparam int ADDR_W = MAX_LOG2N - 2;

  logic              start;
  logic              abort;
  logic [3:0]        log2n;
  logic [ADDR_W-1:0] addr_rd_0;
  logic [ADDR_W-1:0] addr_rd_1;
  logic [ADDR_W-1:0] addr_rd_2;
  logic [ADDR_W-1:0] addr_rd_3;
  logic [1:0]        bank_rd_rot;
  logic [4*ADDR_W-1:0] addr_wr;
  logic [1:0]        bank_wr_rot;
  logic [ADDR_W-1:0] addr_coef;
  logic              we_a;
  logic              we_b;
  logic              source_data;
  logic              source_cont;
  logic              but_type;
  logic              busy;
  logic              rdy;

  modport master (
    output start, abort, log2n,
    input  addr_rd_0, addr_rd_1, addr_rd_2, addr_rd_3, bank_rd_rot, addr_wr,
           bank_wr_rot, addr_coef, we_a, we_b, source_data, source_cont,
           but_type, busy, rdy
  );

  modport slave (
    input  start, abort, log2n,
    output addr_rd_0, addr_rd_1, addr_rd_2, addr_rd_3, bank_rd_rot, addr_wr,
           bank_wr_rot, addr_coef, we_a, we_b, source_data, source_cont,
           but_type, busy, rdy
  );
endinterface

// File: rtl/fft_control_param.sv
// Run-time sized radix-4/radix-2 FFT sequencer: four-bank read addressing, twiddle
// addresses and a PIPE_LAT-deep write-side delay line for the ping-pong memories.
module fft_control_param #(
  parameter int MAX_LOG2N = 10,
  parameter int PIPE_LAT  = 4
) (
  input logic                clk,
  input logic                rst_n,
  fft_control_param_if.slave bus
);
  localparam int ADDR_W = MAX_LOG2N - 2;
  localparam int NDIG   = (MAX_LOG2N + 1) / 2;
  localparam int DW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [3:0]    MAX_L      = 4'(MAX_LOG2N);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, NEXT, DONE} state_e;

  typedef struct packed {
    logic [4*ADDR_W-1:0] addr;
    logic [1:0]          rot;
    logic                but_type;
    logic                we_a;
    logic                we_b;
  } wr_t;

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_max, coef;
  logic [DW-1:0]       drain_cnt;
  logic [3:0]          l_reg, stage, last_stage, span_log, coef_sh;
  logic                legal, run, radix2, cnt_end, drain_end, busy;
  logic [MAX_LOG2N-1:0] cnt_w, mask;
  logic [MAX_LOG2N-1:0] elem [4];
  logic [1:0]          bank [4];
  logic [ADDR_W-1:0]   rd [4];
  logic [1:0]          rot;
  wr_t                 rd_word;
  wr_t                 pipe [PIPE_LAT];

  assign legal      = (bus.log2n >= 4'd4) && (bus.log2n <= MAX_L);
  assign last_stage = 4'((({1'b0, l_reg} + 5'd1) >> 1) - 5'd1);
  assign cnt_max    = {ADDR_W{1'b1}} >> (MAX_L - l_reg);
  assign cnt_end    = (cnt == cnt_max);
  assign drain_end  = (drain_cnt == DRAIN_LAST);
  assign run        = (state == RUN);
  assign busy       = (state != IDLE);
  assign radix2     = l_reg[0] && (stage == last_stage);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && legal) state_nxt = RUN;
      RUN:     if (cnt_end) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = (stage == last_stage) ? DONE : NEXT;
      NEXT:    state_nxt = RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      drain_cnt <= '0;
      stage     <= '0;
      l_reg     <= '0;
    end else if (bus.abort) begin
      cnt       <= '0;
      drain_cnt <= '0;
      stage     <= '0;
    end else begin
      case (state)
        IDLE:    if (bus.start && legal) l_reg <= bus.log2n;
        RUN:     cnt <= cnt_end ? '0 : cnt + 1'b1;
        DRAIN:   drain_cnt <= drain_end ? '0 : drain_cnt + 1'b1;
        NEXT:    stage <= stage + 4'd1;
        DONE:    stage <= '0;
        default: ;
      endcase
    end
  end

  // Radix-4 legs: the leg index is a base-4 digit spliced into cnt at bit span_log.
  assign span_log = l_reg - {stage[2:0], 1'b0} - 4'd2;
  assign coef_sh  = {stage[2:0], 1'b0};
  assign cnt_w    = MAX_LOG2N'(cnt);
  assign mask     = ~({MAX_LOG2N{1'b1}} << span_log);

  function automatic logic [1:0] digit_sum(input logic [MAX_LOG2N-1:0] e);
    logic [2*NDIG-1:0] ep;
    logic [1:0]        acc;
    ep  = (2*NDIG)'(e);
    acc = '0;
    for (int d = 0; d < NDIG; d++) acc = acc + ep[2*d +: 2];
    return acc;
  endfunction

  always_comb begin
    for (int b = 0; b < 4; b++) rd[b] = '0;
    for (int j = 0; j < 4; j++) begin
      elem[j] = radix2 ? {cnt, 2'(j)}
                       : (((cnt_w & ~mask) << 2) | (MAX_LOG2N'(j) << span_log) | (cnt_w & mask));
      bank[j] = digit_sum(elem[j]);
      if (run) rd[bank[j]] = elem[j][MAX_LOG2N-1:2];
    end
  end

  assign rot  = run ? bank[0] : 2'b00;
  assign coef = (run && !radix2) ? ADDR_W'((cnt_w & mask) << coef_sh) : '0;

  assign rd_word = '{addr:     {rd[3], rd[2], rd[1], rd[0]},
                     rot:      rot,
                     but_type: run & radix2,
                     we_a:     run & stage[0],
                     we_b:     run & ~stage[0]};

  // NOTE: the delay line is reset and abort-flushed because it carries write enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
    end else if (bus.abort) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= rd_word;
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign bus.addr_rd_0   = rd[0];
  assign bus.addr_rd_1   = rd[1];
  assign bus.addr_rd_2   = rd[2];
  assign bus.addr_rd_3   = rd[3];
  assign bus.bank_rd_rot = rot;
  assign bus.addr_coef   = coef;
  assign bus.addr_wr     = pipe[PIPE_LAT-1].addr;
  assign bus.bank_wr_rot = pipe[PIPE_LAT-1].rot;
  assign bus.but_type    = pipe[PIPE_LAT-1].but_type;
  assign bus.we_a        = pipe[PIPE_LAT-1].we_a;
  assign bus.we_b        = pipe[PIPE_LAT-1].we_b;
  assign bus.source_data = busy & stage[0];
  assign bus.source_cont = busy;
  assign bus.busy        = busy;
  assign bus.rdy         = (state == DONE);
endmodule

// File: tb/tb_fft_control_param.sv
// Directed bench for fft_control_param: hand-computed vector table for L=4/L=5 traces,
// plus reset, abort, illegal-size and full L=10 schedule checks against a small model.
module tb_fft_control_param;
  localparam int MAX_LOG2N = 10;
  localparam int PIPE_LAT  = 4;
  localparam int ADDR_W    = MAX_LOG2N - 2;
  localparam int NS        = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_control_param_if #(.MAX_LOG2N(MAX_LOG2N)) bus ();
  fft_control_param #(.MAX_LOG2N(MAX_LOG2N), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef enum int {S_BUSY, S_RDY, S_WEA, S_WEB, S_BT, S_SRC, S_ROT, S_COEF,
                    S_RD0, S_RD1, S_RD2, S_RD3, S_WROT, S_WADDR, S_CONT} sig_e;
  typedef struct { int l; int cyc; sig_e sig; logic [31:0] exp; } vec_t;

  vec_t        vecs[$];
  logic [31:0] tr [0:63][0:NS-1];
  int          n_checks = 0, n_fail = 0;
  int          m_rd [4];
  int          m_rot, m_coef, m_bank_clash = 0;
  bit          m_run, m_odd, m_busy, m_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int l, input int c, input sig_e s, input logic [31:0] e);
    vec_t v;
    v.l = l; v.cyc = c; v.sig = s; v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] probe(input sig_e s);
    case (s)
      S_BUSY:  return 32'(bus.busy);
      S_RDY:   return 32'(bus.rdy);
      S_WEA:   return 32'(bus.we_a);
      S_WEB:   return 32'(bus.we_b);
      S_BT:    return 32'(bus.but_type);
      S_SRC:   return 32'(bus.source_data);
      S_ROT:   return 32'(bus.bank_rd_rot);
      S_COEF:  return 32'(bus.addr_coef);
      S_RD0:   return 32'(bus.addr_rd_0);
      S_RD1:   return 32'(bus.addr_rd_1);
      S_RD2:   return 32'(bus.addr_rd_2);
      S_RD3:   return 32'(bus.addr_rd_3);
      S_WROT:  return 32'(bus.bank_wr_rot);
      S_WADDR: return 32'(bus.addr_wr);
      S_CONT:  return 32'(bus.source_cont);
      default: return 32'd0;
    endcase
  endfunction

  task automatic sample(input int c);
    for (int k = 0; k < NS; k++) tr[c][k] = probe(sig_e'(k));
  endtask

  // Cycle 0 is the cycle in which start is driven; cycle c is sampled c negedges later.
  task automatic run_trace(input int l, input int ncyc, input int restart_cyc);
    @(negedge clk);
    bus.log2n = 4'(l);
    bus.start = 1'b1;
    sample(0);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      sample(c);
      bus.start = (c == restart_cyc);
      if (c == restart_cyc) bus.log2n = 4'd5;
    end
  endtask

  task automatic check_table(input int l);
    foreach (vecs[i])
      if (vecs[i].l == l)
        check($sformatf("L%0d_c%0d_%s", l, vecs[i].cyc, vecs[i].sig.name()),
              tr[vecs[i].cyc][int'(vecs[i].sig)], vecs[i].exp);
  endtask

  function automatic int count_sig(input sig_e s, input int ncyc);
    int n = 0;
    for (int c = 0; c <= ncyc; c++) n += int'(tr[c][int'(s)] != 0);
    return n;
  endfunction

  // Schedule model written from the textbook formulas (division/modulo, base-4 digits).
  task automatic model_at(input int l, input int c);
    int  q, ns, blk, k, s, cnt, span, e, x, ds, b;
    bit  seen [4];
    bit  r2;
    for (int i = 0; i < 4; i++) begin m_rd[i] = 0; seen[i] = 1'b0; end
    m_rot = 0; m_coef = 0; m_run = 1'b0; m_odd = 1'b0;
    q   = 1 << (l - 2);
    ns  = (l + 1) / 2;
    blk = q + PIPE_LAT + 1;
    k   = c - 1;
    m_busy = (k >= 0) && (k < ns * blk);
    m_rdy  = (c == ns * blk);
    if (!m_busy) return;
    s = k / blk;
    cnt = k % blk;
    m_odd = (s % 2) == 1;
    if (cnt >= q) return;
    m_run = 1'b1;
    r2 = (l % 2 == 1) && (s == ns - 1);
    span = q / (4 ** s);
    for (int j = 0; j < 4; j++) begin
      e = r2 ? 4 * cnt + j : (cnt / span) * 4 * span + j * span + cnt % span;
      ds = 0;
      x = e;
      while (x > 0) begin ds += x % 4; x = x / 4; end
      b = ds % 4;
      if (seen[b]) m_bank_clash++;
      seen[b] = 1'b1;
      m_rd[b] = e / 4;
      if (j == 0) m_rot = b;
    end
    m_coef = r2 ? 0 : (cnt % span) * (4 ** s);
  endtask

  task automatic run_model(input int l, input int limit, output int rdy_cyc, output int errs);
    bit ewa, ewb;
    rdy_cyc = -1;
    errs = 0;
    @(negedge clk);
    bus.log2n = 4'(l);
    bus.start = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      model_at(l, c - PIPE_LAT);
      ewa = m_run & m_odd;
      ewb = m_run & !m_odd;
      model_at(l, c);
      if (bus.addr_rd_0 !== ADDR_W'(m_rd[0]) || bus.addr_rd_1 !== ADDR_W'(m_rd[1]) ||
          bus.addr_rd_2 !== ADDR_W'(m_rd[2]) || bus.addr_rd_3 !== ADDR_W'(m_rd[3]) ||
          bus.bank_rd_rot !== 2'(m_rot) || bus.addr_coef !== ADDR_W'(m_coef) ||
          bus.we_a !== ewa || bus.we_b !== ewb || bus.busy !== m_busy ||
          bus.rdy !== m_rdy || bus.source_data !== (m_busy & m_odd)) begin
        errs++;
        if (errs == 1) $display("  first difference: L=%0d cycle %0d", l, c);
      end
      if (bus.rdy) begin
        rdy_cyc = c;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, errs, act;

    // L=4: two radix-4 stages, RUN 1..4 / 10..13, DRAIN 5..8 / 14..17, NEXT 9, DONE 18.
    add(4, 0, S_BUSY, 0);  add(4, 1, S_BUSY, 1);  add(4, 1, S_CONT, 1);
    add(4, 1, S_RD0, 0);   add(4, 1, S_RD1, 1);   add(4, 1, S_RD2, 2);  add(4, 1, S_RD3, 3);
    add(4, 2, S_RD0, 3);   add(4, 2, S_RD1, 0);   add(4, 2, S_RD2, 1);  add(4, 2, S_RD3, 2);
    add(4, 2, S_ROT, 1);   add(4, 2, S_COEF, 1);
    add(4, 5, S_RD0, 0);   add(4, 5, S_WEB, 1);   add(4, 5, S_WEA, 0);
    add(4, 6, S_WROT, 1);  add(4, 6, S_WADDR, 32'h0201_0003);
    add(4, 8, S_WEB, 1);   add(4, 9, S_WEB, 0);   add(4, 9, S_BUSY, 1); add(4, 9, S_SRC, 0);
    add(4, 10, S_SRC, 1);  add(4, 10, S_RD1, 0);  add(4, 11, S_RD0, 1); add(4, 11, S_ROT, 1);
    add(4, 13, S_RD3, 3);  add(4, 13, S_ROT, 3);
    add(4, 14, S_WEA, 1);  add(4, 14, S_WEB, 0);  add(4, 17, S_WEA, 1); add(4, 17, S_RDY, 0);
    add(4, 18, S_RDY, 1);  add(4, 18, S_WEA, 0);  add(4, 18, S_BUSY, 1);
    add(4, 19, S_BUSY, 0); add(4, 19, S_RDY, 0);  add(4, 19, S_SRC, 0);
    // L=5: stages 0,1 radix-4 (RUN 1..8, 14..21), stage 2 dual radix-2 (RUN 27..34), DONE 39.
    add(5, 4, S_RD0, 4);   add(5, 4, S_RD1, 2);   add(5, 4, S_RD2, 6);  add(5, 4, S_RD3, 0);
    add(5, 4, S_ROT, 3);   add(5, 4, S_COEF, 3);  add(5, 4, S_BT, 0);
    add(5, 8, S_WROT, 3);  add(5, 8, S_WADDR, 32'h0006_0204); add(5, 8, S_WEB, 1);
    add(5, 19, S_RD0, 4);  add(5, 19, S_RD1, 5);  add(5, 19, S_RD2, 4); add(5, 19, S_RD3, 5);
    add(5, 19, S_ROT, 2);  add(5, 19, S_COEF, 4); add(5, 19, S_SRC, 1);
    add(5, 23, S_WEA, 1);  add(5, 30, S_BT, 0);   add(5, 31, S_BT, 1);
    add(5, 33, S_ROT, 3);  add(5, 33, S_RD1, 6);  add(5, 33, S_COEF, 0); add(5, 33, S_SRC, 0);
    add(5, 37, S_BT, 1);   add(5, 37, S_WEB, 1);  add(5, 38, S_WEB, 1); add(5, 38, S_RDY, 0);
    add(5, 39, S_RDY, 1);  add(5, 39, S_WEB, 0);  add(5, 40, S_BUSY, 0);

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.log2n = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_rdy", 32'(bus.rdy), 0);
    check("reset_we", 32'({bus.we_a, bus.we_b}), 0);
    check("reset_addr_wr", 32'(bus.addr_wr), 0);
    check("reset_cont", 32'(bus.source_cont), 0);
    rst_n = 1'b1;

    // L=4 with a second start at cycle 5 that must be ignored.
    run_trace(4, 28, 5);
    check_table(4);
    check("L4_rdy_pulses", count_sig(S_RDY, 28), 1);
    check("L4_web_cycles", count_sig(S_WEB, 28), 4);
    check("L4_wea_cycles", count_sig(S_WEA, 28), 4);

    run_trace(5, 45, -1);
    check_table(5);
    check("L5_web_cycles", count_sig(S_WEB, 45), 16);
    check("L5_wea_cycles", count_sig(S_WEA, 45), 8);
    check("L5_bt_cycles", count_sig(S_BT, 45), 8);

    // Asynchronous reset in the middle of stage 0.
    @(negedge clk);
    bus.log2n = 4'd4;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 0);
    check("rst_mid_rd", 32'({bus.addr_rd_0, bus.addr_rd_1, bus.addr_rd_2, bus.addr_rd_3}), 0);
    check("rst_mid_rot", 32'(bus.bank_rd_rot), 0);
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (12) begin
      @(negedge clk);
      act += int'(bus.we_a | bus.we_b | bus.busy | bus.rdy);
    end
    check("rst_mid_no_activity", act, 0);

    // Illegal sizes and start together with abort.
    foreach (vecs[i]) if (i < 3) begin
      logic [3:0] ls;
      ls = (i == 0) ? 4'd3 : 4'd11;
      @(negedge clk);
      bus.log2n = ls;
      bus.start = 1'b1;
      bus.abort = (i == 2);
      if (i == 2) bus.log2n = 4'd4;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check($sformatf("idle_start_%0d_busy1", i), 32'(bus.busy), 0);
      repeat (2) @(negedge clk);
      check($sformatf("idle_start_%0d_busy3", i), 32'(bus.busy), 0);
    end

    // Full maximum-size transform against the model.
    run_model(10, 1400, rc, errs);
    check("L10_rdy_cycle", rc, 1305);
    check("L10_schedule", errs, 0);
    check("L10_bank_distinct", m_bank_clash, 0);
    repeat (3) @(negedge clk);

    // Abort at cycle 100 of an L=10 run, then an immediate L=4 restart.
    run_model(10, 100, rc, errs);
    check("abort_prefix_no_rdy", rc, -1);
    check("abort_prefix_schedule", errs, 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_we", 32'({bus.we_a, bus.we_b}), 0);
    act = 0;
    repeat (10) begin
      @(negedge clk);
      act += int'(bus.we_a | bus.we_b | bus.busy | bus.rdy);
    end
    check("abort_no_trailing", act, 0);
    run_model(4, 40, rc, errs);
    check("restart_rdy_cycle", rc, 18);
    check("restart_schedule", errs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
